// File: rtl/pila_param.sv
// Parametrised LIFO return-address stack with full/empty status, occupancy
// count, sticky overflow/underflow flags and a replace-top push+pop.
module pila_param #(
    parameter  int WIDTH = 10,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_err,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             udf
);

    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic [AW:0]      top_m1;
    logic [AW-1:0]    top_idx;
    logic             is_empty, is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_MAX);
    assign top_m1   = count_q - CNT_ONE;
    assign top_idx  = top_m1[AW-1:0];

    // Error flags: clear first, so a same-cycle error event overrides clr_err.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q & ~clr_err;
        udf_d   = udf_q & ~clr_err;
        wr_en   = 1'b0;
        wr_idx  = count_q[AW-1:0];
        case ({push, pop})
            2'b10: begin
                if (is_full) begin
                    ovf_d = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    count_d = count_q + CNT_ONE;
                end
            end
            2'b01: begin
                if (is_empty) begin
                    udf_d = 1'b1;
                end else begin
                    count_d = top_m1;
                end
            end
            2'b11: begin
                wr_en = 1'b1;
                if (is_empty) begin
                    udf_d   = 1'b1;
                    wr_idx  = '0;
                    count_d = CNT_ONE;
                end else begin
                    wr_idx = top_idx;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage carries no reset; its contents are only visible below count.
    always_ff @(posedge clk) begin
        if (wr_en && reset) begin
            mem_q[wr_idx] <= din;
        end
    end

    assign dout  = is_empty ? '0 : mem_q[top_idx];
    assign count = count_q;
    assign empty = is_empty;
    assign full  = is_full;
    assign ovf   = ovf_q;
    assign udf   = udf_q;

endmodule

// File: tb/tb_pila_param.sv
// Bench for pila_param: default instance (8 x 10) and a 5 x 12 instance,
// driven from vector tables with a scoreboard queue of expected outputs.
module tb_pila_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        push, pop, clr_err;
    logic [11:0] din;
    logic        sel;

    logic [9:0]  dout_a;
    logic [3:0]  count_a;
    logic        empty_a, full_a, ovf_a, udf_a;
    logic [11:0] dout_b;
    logic [3:0]  count_b;
    logic        empty_b, full_b, ovf_b, udf_b;

    logic [11:0] cur_dout;
    logic [3:0]  cur_count;
    logic        cur_empty, cur_full, cur_ovf, cur_udf;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        push, pop, clr;
        logic [11:0] din;
        int          cnt;
        logic [11:0] dout;
        logic        full, empty, ovf, udf;
        logic        chk_pre;
        logic [11:0] pre;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    pila_param u_a (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din[9:0]),
        .clr_err(clr_err), .dout(dout_a), .count(count_a), .empty(empty_a),
        .full(full_a), .ovf(ovf_a), .udf(udf_a)
    );

    pila_param #(.WIDTH(12), .DEPTH(5)) u_b (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din),
        .clr_err(clr_err), .dout(dout_b), .count(count_b), .empty(empty_b),
        .full(full_b), .ovf(ovf_b), .udf(udf_b)
    );

    always_comb begin
        cur_dout  = sel ? dout_b  : {2'b00, dout_a};
        cur_count = sel ? count_b : count_a;
        cur_empty = sel ? empty_b : empty_a;
        cur_full  = sel ? full_b  : full_a;
        cur_ovf   = sel ? ovf_b   : ovf_a;
        cur_udf   = sel ? udf_b   : udf_a;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic void add(input logic pu, input logic po, input logic cl,
                                input logic [11:0] d, input int cnt, input logic [11:0] q,
                                input logic fu, input logic em, input logic ov, input logic ud,
                                input logic cp = 1'b0, input logic [11:0] pre = 12'h000);
        vec_t v;
        v.push = pu; v.pop = po; v.clr = cl; v.din = d;
        v.cnt = cnt; v.dout = q; v.full = fu; v.empty = em; v.ovf = ov; v.udf = ud;
        v.chk_pre = cp; v.pre = pre;
        tbl.push_back(v);
    endfunction

    task automatic check_outputs(input string tag, input vec_t e);
        chk({tag, "_count"}, 32'(cur_count), 32'(e.cnt));
        chk({tag, "_dout"},  32'(cur_dout),  32'(e.dout));
        chk({tag, "_full"},  32'(cur_full),  32'(e.full));
        chk({tag, "_empty"}, 32'(cur_empty), 32'(e.empty));
        chk({tag, "_ovf"},   32'(cur_ovf),   32'(e.ovf));
        chk({tag, "_udf"},   32'(cur_udf),   32'(e.udf));
    endtask

    task automatic run_tbl(input string tag);
        vec_t v, e;
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            @(negedge clk);
            push = v.push; pop = v.pop; clr_err = v.clr; din = v.din;
            exp_q.push_back(v);
            if (v.chk_pre) begin
                #1;
                chk($sformatf("%s%0d_pre_dout", tag, i), 32'(cur_dout), 32'(v.pre));
            end
            @(posedge clk);
            #1;
            push = 1'b0; pop = 1'b0; clr_err = 1'b0; din = '0;
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL %s%0d scoreboard underrun", tag, i);
            end else begin
                e = exp_q.pop_front();
                check_outputs($sformatf("%s%0d", tag, i), e);
            end
        end
        tbl.delete();
    endtask

    task automatic async_reset(input string tag);
        vec_t e;
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        e.cnt = 0; e.dout = '0; e.full = 1'b0; e.empty = 1'b1; e.ovf = 1'b0; e.udf = 1'b0;
        check_outputs(tag, e);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t e;
        sel = 1'b0; reset = 1'b0;
        push = 1'b0; pop = 1'b0; clr_err = 1'b0; din = '0;
        #2;
        e.cnt = 0; e.dout = '0; e.full = 1'b0; e.empty = 1'b1; e.ovf = 1'b0; e.udf = 1'b0;
        check_outputs("por", e);
        #6;
        reset = 1'b1;

        // LIFO order, overflow, underflow, replace-top, flag priority
        for (int i = 1; i <= 8; i++) add(1, 0, 0, 12'(i), i, 12'(i), i == 8, 0, 0, 0);
        add(1, 0, 0, 12'h3FF, 8, 12'h008, 1, 0, 1, 0);
        for (int k = 0; k < 8; k++)
            add(0, 1, 0, 12'h000, 7 - k, 12'(7 - k), 0, k == 7, 1, 0, 1, 12'(8 - k));
        add(0, 1, 0, 12'h000, 0, 12'h000, 0, 1, 1, 1);
        add(1, 1, 0, 12'h155, 1, 12'h155, 0, 0, 1, 1);
        add(0, 0, 1, 12'h000, 1, 12'h155, 0, 0, 0, 0);
        add(1, 0, 0, 12'h002, 2, 12'h002, 0, 0, 0, 0);
        add(1, 0, 0, 12'h003, 3, 12'h003, 0, 0, 0, 0);
        add(1, 1, 0, 12'h155, 3, 12'h155, 0, 0, 0, 0);
        add(0, 1, 0, 12'h000, 2, 12'h002, 0, 0, 0, 0, 1, 12'h155);
        for (int i = 3; i <= 8; i++) add(1, 0, 0, 12'(i), i, 12'(i), i == 8, 0, 0, 0);
        add(1, 1, 0, 12'h2AA, 8, 12'h2AA, 1, 0, 0, 0);
        add(1, 0, 0, 12'h111, 8, 12'h2AA, 1, 0, 1, 0);
        add(1, 0, 1, 12'h111, 8, 12'h2AA, 1, 0, 1, 0);
        add(0, 0, 1, 12'h000, 8, 12'h2AA, 1, 0, 0, 0);
        add(1, 0, 0, 12'h111, 8, 12'h2AA, 1, 0, 1, 0);
        add(0, 1, 0, 12'h000, 7, 12'h007, 0, 0, 1, 0, 1, 12'h2AA);
        add(0, 1, 0, 12'h000, 6, 12'h006, 0, 0, 1, 0, 1, 12'h007);
        add(0, 1, 0, 12'h000, 5, 12'h005, 0, 0, 1, 0, 1, 12'h006);
        run_tbl("a");

        // Mid-cycle asynchronous reset with count=5, ovf=1
        async_reset("arst_a");
        add(1, 0, 0, 12'h0AA, 1, 12'h0AA, 0, 0, 0, 0);
        add(0, 1, 0, 12'h000, 0, 12'h000, 0, 1, 0, 0, 1, 12'h0AA);
        run_tbl("a_post");

        // DEPTH=5, WIDTH=12 instance
        sel = 1'b1;
        async_reset("arst_b");
        for (int i = 1; i <= 5; i++)
            add(1, 0, 0, 12'hA00 + 12'(i), i, 12'hA00 + 12'(i), i == 5, 0, 0, 0);
        add(1, 0, 0, 12'hFFF, 5, 12'hA05, 1, 0, 1, 0);
        for (int k = 0; k < 5; k++)
            add(0, 1, 0, 12'h000, 4 - k, (k == 4) ? 12'h000 : 12'hA00 + 12'(4 - k),
                0, k == 4, 1, 0, 1, 12'hA05 - 12'(k));
        add(0, 1, 1, 12'h000, 0, 12'h000, 0, 1, 0, 1);
        run_tbl("b");

        if (exp_q.size() != 0) begin
            checks++; failures++;
            $display("FAIL scoreboard leftover=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pila_param.md
Name: pila_param

Overview:
- Parametrised LIFO stack that replaces the fixed 8-deep, 10-bit return-address stack used by the CPU for subroutine call/return.
- Fully synchronous push/pop on the rising edge of clk, with a combinational top-of-stack read.
- Adds full/empty status, an occupancy count, sticky overflow/underflow error flags, and a defined simultaneous push+pop (replace-top) operation.
- Sits between the PC logic (push = return address on call, pop = return address on ret) and the PC mux.

Parameters:
- WIDTH, 10, bit width of each stored entry (PC width).
- DEPTH, 8, number of entries; any integer >= 2, not required to be a power of two.
- AW (localparam), $clog2(DEPTH), index width; the count is AW+1 bits wide.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- push  input  1  write din onto the stack this cycle.
- pop  input  1  remove the top entry this cycle.
- din  input  WIDTH  data to push.
- clr_err  input  1  synchronous clear of ovf/udf.
- dout  output  WIDTH  top of stack, combinational: mem[count-1] when count>0, else 0.
- count  output  AW+1  number of valid entries, 0..DEPTH.
- empty  output  1  count==0, combinational.
- full  output  1  count==DEPTH, combinational.
- ovf  output  1  sticky overflow flag.
- udf  output  1  sticky underflow flag.

Behaviour:
- Reset (reset==0, asynchronous, takes effect without a clock edge):
  - count=0, ovf=0, udf=0, so empty=1, full=0, dout=0.
  - Storage contents are not cleared and are don't-care.
  - Reset has priority over all other inputs at every time.
- Operations per rising edge (reset==1), decoded from {push,pop}:
  - 00: no change.
  - 10, not full: mem[count]<=din; count<=count+1.
  - 10, full: storage and count unchanged; ovf<=1.
  - 01, not empty: count<=count-1. The popped value is dout during that same cycle (before the edge).
  - 01, empty: count unchanged; udf<=1.
  - 11, not empty (including full): replace top, mem[count-1]<=din; count unchanged; no flag set.
  - 11, empty: the pop is illegal, so udf<=1; the push proceeds: mem[0]<=din, count<=1.
- Flags:
  - ovf and udf stay at 1 until cleared by clr_err or reset.
  - clr_err==1 clears both flags at the edge.
  - If an error event occurs in the same cycle as clr_err, set wins and that flag is 1 after the edge.
- Latency:
  - dout, empty and full reflect a new count and top entry immediately after the edge that changed them (zero-cycle read).
  - There is no read enable.
- Arithmetic:
  - count never leaves 0..DEPTH; there is no wrap-around.
  - Writes address only the indices 0..DEPTH-1.
  - dout never reads mem[count-1] while count==0.
- Input changes between edges must not alter state. Level-sensitive, unclocked updates are forbidden.
- The X-free requirement applies to dout only while empty==1, where dout must be 0.

Test Plan:
- Stack contents and LIFO order (defaults, after reset): push 0x001..0x008 over 8 cycles, then pop 8 times.
  - After the pushes: count=8, full=1.
  - During the pops, dout reads 0x008, 0x007, …, 0x001 in the pop cycles; after the last pop, count=0, empty=1, dout=0.
- Overflow: stack full with top 0x008, push din=0x3FF.
  - Response: ovf=1, count=8, dout=0x008; a following pop returns 0x008.
- Underflow: stack empty, pop 1 cycle.
  - Response: udf=1, count=0, dout=0.
  - Then push+pop din=0x155 in one cycle: udf stays 1, count=1, dout=0x155.
- Replace-top: count=3 with top 0x003, push+pop din=0x155.
  - Response: count=3, dout=0x155.
  - A next pop yields dout=0x155 in that cycle; afterwards dout=0x002.
  - Repeat at full: count stays 8, ovf stays 0.
- Flag clear priority: with ovf=1 and the stack full, assert clr_err together with push.
  - Response: ovf stays 1.
  - Then clr_err alone gives ovf=0, udf=0 after one edge.
- Asynchronous reset: with count=5 and ovf=1, drive reset=0 mid-cycle, away from any clk edge.
  - Response, without waiting for a clock edge: count=0, empty=1, ovf=0, dout=0.
  - After reset=1, push 0x0AA gives count=1, dout=0x0AA.
  - Rerun the LIFO-order and overflow scenarios with DEPTH=5, WIDTH=12: full asserts at count=5.
